// File: rtl/remote_comm.sv
// ============================================================================
// Module   : remote_comm
// Purpose  : Host-side command link. It sends a 16-bit command over UART 8N1
//            as two bytes, high byte first, and receives single-byte responses.
// Options  : FRAMING_CHECK_EN - when defined, frames with a bad stop bit are dropped.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module remote_comm #(
  parameter int BAUD_DIV = 2604
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RX,
  output logic        TX,
  input  logic [15:0] cmd,
  input  logic        snd_cmd,
  output logic        cmd_snt,
  output logic        resp_rdy,
  output logic [7:0]  resp
);

  localparam int CW = (BAUD_DIV > 4095) ? $clog2(BAUD_DIV) : 12;
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);

  typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW, S_DONE} cmd_state_t;
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_WAIT} rx_state_t;

  cmd_state_t    state_q;
  logic [15:0]   cmd_q;
  logic          tx_start_q;
  logic          cmd_snt_q;

  logic          tx_busy_q;
  logic [8:0]    tx_shift_q;
  logic [3:0]    tx_bit_q;
  logic [CW-1:0] tx_cnt_q;

  rx_state_t     rx_state_q;
  logic          rx_meta_q, rx_sync_q, rx_prev_q;
  logic [CW-1:0] rx_cnt_q;
  logic [3:0]    rx_bit_q;
  logic [7:0]    rx_shift_q;
  logic [7:0]    resp_q;
  logic          resp_rdy_q;

  logic          accept;
  logic          tx_tick;
  logic          tx_done;
  logic [7:0]    tx_byte;

  assign accept  = (state_q == S_IDLE) && snd_cmd;
  assign tx_tick = tx_busy_q && (tx_cnt_q == BAUD_LAST);
  assign tx_done = tx_tick && (tx_bit_q == 4'd9);
  // The byte to load follows the FSM state the start pulse is issued in.
  assign tx_byte = (state_q == S_HIGH) ? cmd_q[15:8] : cmd_q[7:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cmd_q      <= 16'h0000;
      tx_start_q <= 1'b0;
      cmd_snt_q  <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      case (state_q)
        S_IDLE: if (snd_cmd) begin
          cmd_q      <= cmd;
          cmd_snt_q  <= 1'b0;
          tx_start_q <= 1'b1;
          state_q    <= S_HIGH;
        end
        S_HIGH: if (tx_done) begin
          tx_start_q <= 1'b1;
          state_q    <= S_LOW;
        end
        S_LOW: if (tx_done) begin
          cmd_snt_q <= 1'b1;
          state_q   <= S_DONE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Shift register idles at all ones, so its LSB is the line level directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_busy_q  <= 1'b0;
      tx_shift_q <= 9'h1FF;
      tx_bit_q   <= 4'd0;
      tx_cnt_q   <= '0;
    end else if (tx_start_q && !tx_busy_q) begin
      tx_busy_q  <= 1'b1;
      tx_shift_q <= {tx_byte, 1'b0};
      tx_bit_q   <= 4'd0;
      tx_cnt_q   <= '0;
    end else if (tx_busy_q) begin
      if (tx_tick) begin
        tx_cnt_q   <= '0;
        tx_shift_q <= {1'b1, tx_shift_q[8:1]};
        tx_bit_q   <= tx_bit_q + 4'd1;
        if (tx_bit_q == 4'd9) tx_busy_q <= 1'b0;
      end else begin
        tx_cnt_q <= tx_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_q <= R_IDLE;
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_cnt_q   <= '0;
      rx_bit_q   <= 4'd0;
      rx_shift_q <= 8'h00;
      resp_q     <= 8'h00;
      resp_rdy_q <= 1'b0;
    end else begin
      rx_meta_q <= RX;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
      if (accept) resp_rdy_q <= 1'b0;
      case (rx_state_q)
        R_IDLE: if (rx_prev_q && !rx_sync_q) begin
          rx_state_q <= R_START;
          rx_cnt_q   <= '0;
          resp_rdy_q <= 1'b0;
        end
        R_START: if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_q   <= '0;
          rx_bit_q   <= 4'd0;
          rx_state_q <= rx_sync_q ? R_IDLE : R_DATA;
        end else begin
          rx_cnt_q <= rx_cnt_q + 1'b1;
        end
        R_DATA: if (rx_cnt_q == BAUD_LAST) begin
          rx_cnt_q <= '0;
          if (rx_bit_q == 4'd8) begin
`ifdef FRAMING_CHECK_EN
            if (rx_sync_q) begin
              resp_q     <= rx_shift_q;
              resp_rdy_q <= 1'b1;
              rx_state_q <= R_IDLE;
            end else begin
              rx_state_q <= R_WAIT;
            end
`else
            resp_q     <= rx_shift_q;
            resp_rdy_q <= 1'b1;
            rx_state_q <= R_IDLE;
`endif
          end else begin
            rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
            rx_bit_q   <= rx_bit_q + 4'd1;
          end
        end else begin
          rx_cnt_q <= rx_cnt_q + 1'b1;
        end
        default: if (rx_sync_q) rx_state_q <= R_IDLE;
      endcase
    end
  end

  assign TX       = tx_shift_q[0];
  assign cmd_snt  = cmd_snt_q;
  assign resp_rdy = resp_rdy_q;
  assign resp     = resp_q;

endmodule

`default_nettype wire

// File: tb/tb_remote_comm.sv
// ============================================================================
// Module   : tb_remote_comm
// Purpose  : Self-checking bench for remote_comm with BAUD_DIV=16; TX bytes are
//            checked against a scoreboard queue and RX frames are driven from a table.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_remote_comm;

  localparam int BAUD = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        RX = 1'b1;
  logic        TX;
  logic [15:0] cmd = 16'h0000;
  logic        snd_cmd = 1'b0;
  logic        cmd_snt;
  logic        resp_rdy;
  logic [7:0]  resp;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_start = 0;
  int prev_start = 0;
  bit abort = 1'b0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       glitch;
    logic       exp_rdy;
    logic [7:0] exp_resp;
  } rx_vec_t;

  rx_vec_t rx_tab[6];
  logic [15:0] cmd_tab[3];

  remote_comm #(.BAUD_DIV(BAUD)) dut (
    .clk(clk), .rst(rst), .RX(RX), .TX(TX), .cmd(cmd), .snd_cmd(snd_cmd),
    .cmd_snt(cmd_snt), .resp_rdy(resp_rdy), .resp(resp)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic chk_range(input string nm, input int val, input int lo, input int hi);
    checks++;
    if (val < lo || val > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", nm, val, lo, hi);
    end
  endtask

  // TX line decoder: pops the scoreboard for every byte seen on the wire.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && TX === 1'b0) begin
        logic [7:0] b;
        prev_start = last_start;
        last_start = cyc;
        repeat (BAUD/2 - 1) @(negedge clk);
        if (!abort) chk("tx_start_bit", {31'd0, TX}, 32'd0);
        for (int i = 0; i < 8; i++) begin
          repeat (BAUD) @(negedge clk);
          b[i] = TX;
        end
        repeat (BAUD) @(negedge clk);
        if (!abort) begin
          chk("tx_stop_bit", {31'd0, TX}, 32'd1);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL tx_byte: got %0h expected none", b);
          end else begin
            chk("tx_byte", {24'd0, b}, {24'd0, exp_q.pop_front()});
          end
        end
      end
    end
  end

  task automatic do_cmd(input logic [15:0] c, input bit poke);
    int n;
    @(negedge clk);
    cmd = c;
    snd_cmd = 1'b1;
    exp_q.push_back(c[15:8]);
    exp_q.push_back(c[7:0]);
    @(negedge clk);
    snd_cmd = 1'b0;
    chk("snt_clr_on_cmd", {31'd0, cmd_snt}, 32'd0);
    chk("rdy_clr_on_cmd", {31'd0, resp_rdy}, 32'd0);
    if (poke) begin
      repeat (40) @(negedge clk);
      cmd = 16'h1234;
      snd_cmd = 1'b1;
      @(negedge clk);
      snd_cmd = 1'b0;
    end
    n = 0;
    while (!cmd_snt && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("snt_timeout", {31'd0, cmd_snt}, 32'd1);
    chk_range("snt_latency", cyc - last_start, BAUD*10, BAUD*10 + 2);
    chk_range("byte_gap", last_start - prev_start, BAUD*10, BAUD*10 + 1);
    repeat (20) @(negedge clk);
    chk("snt_hold", {31'd0, cmd_snt}, 32'd1);
  endtask

  task automatic rx_apply(input rx_vec_t v);
    @(negedge clk);
    RX = 1'b0;
    if (v.glitch) begin
      repeat (4) @(negedge clk);
      RX = 1'b1;
      repeat (40) @(negedge clk);
    end else begin
      repeat (BAUD/2) @(negedge clk);
      chk("rdy_clr_on_start", {31'd0, resp_rdy}, 32'd0);
      repeat (BAUD/2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        RX = v.data[i];
        repeat (BAUD) @(negedge clk);
      end
      RX = v.stop;
      repeat (BAUD) @(negedge clk);
      RX = 1'b1;
      repeat (4) @(negedge clk);
    end
    chk("rx_rdy", {31'd0, resp_rdy}, {31'd0, v.exp_rdy});
    chk("rx_resp", {24'd0, resp}, {24'd0, v.exp_resp});
  endtask

  initial begin
    bit tx_quiet;
    rx_tab[0] = '{8'hA5, 1'b1, 1'b0, 1'b1, 8'hA5};
    rx_tab[1] = '{8'h3C, 1'b1, 1'b0, 1'b1, 8'h3C};
    rx_tab[2] = '{8'h00, 1'b1, 1'b1, 1'b0, 8'h3C};
`ifdef FRAMING_CHECK_EN
    rx_tab[3] = '{8'h5A, 1'b0, 1'b0, 1'b0, 8'h3C};
`else
    rx_tab[3] = '{8'h5A, 1'b0, 1'b0, 1'b1, 8'h5A};
`endif
    rx_tab[4] = '{8'h00, 1'b1, 1'b0, 1'b1, 8'h00};
    rx_tab[5] = '{8'hFF, 1'b1, 1'b0, 1'b1, 8'hFF};
    cmd_tab[0] = 16'h2F00;
    cmd_tab[1] = 16'hA55A;
    cmd_tab[2] = 16'hFF01;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_tx", {31'd0, TX}, 32'd1);
    chk("rst_snt", {31'd0, cmd_snt}, 32'd0);
    chk("rst_rdy", {31'd0, resp_rdy}, 32'd0);
    chk("rst_resp", {24'd0, resp}, 32'd0);
    repeat (5) @(negedge clk);

    for (int i = 0; i < 6; i++) rx_apply(rx_tab[i]);

    for (int i = 0; i < 3; i++) do_cmd(cmd_tab[i], i == 0);

    // Response arriving while a command is on the wire.
    fork
      do_cmd(16'h8001, 1'b0);
      rx_apply('{8'h77, 1'b1, 1'b0, 1'b1, 8'h77});
    join
    repeat (40) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 32'd0);

    // Reset in the middle of a high byte.
    abort = 1'b1;
    @(negedge clk);
    cmd = 16'hF0F0;
    snd_cmd = 1'b1;
    @(negedge clk);
    snd_cmd = 1'b0;
    repeat (50) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_tx", {31'd0, TX}, 32'd1);
    chk("abort_snt", {31'd0, cmd_snt}, 32'd0);
    chk("abort_rdy", {31'd0, resp_rdy}, 32'd0);
    chk("abort_resp", {24'd0, resp}, 32'd0);
    rst = 1'b0;
    tx_quiet = 1'b1;
    repeat (400) begin
      @(negedge clk);
      if (TX !== 1'b1) tx_quiet = 1'b0;
    end
    chk("abort_tx_quiet", {31'd0, tx_quiet}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
